axis_pkcs7_pad: RTL and testbench
=================================

Name: axis_pkcs7_pad

Overview:
- Upstream neighbour of the AXIS block FIFO.
- Takes a byte-granular AXI-Stream packet (128-bit beats, tkeep marks valid bytes) and emits PKCS#7-padded, fully populated 16-byte blocks for the AES datapath FIFO.
- Adds one extra 16 x 0x10 block when the packet ends on a block boundary.
- Single registered output stage; full throughput when not inserting an extra block.

Parameters:
- DATA_W, 128, beat width in bits; only 128 is legal (one AES block per beat).
- KEEP_W, DATA_W/8, tkeep width in bits (16).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_tdata  in  DATA_W  input beat; byte i = s_tdata[8i+7:8i]
- s_tkeep  in  KEEP_W  byte-valid mask, contiguous from bit 0
- s_tlast  in  1  last beat of packet
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- m_tdata  out  DATA_W  padded block
- m_tkeep  out  KEEP_W  always all ones when m_tvalid=1
- m_tlast  out  1  final block of padded packet
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- err_keep  out  1  sticky: illegal tkeep seen

Behaviour:
- Reset (async, rst_n=0): m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, err_keep=0, state=PASS. Any in-flight packet is discarded; no partial output is completed after reset.
- Output register: load enable ld = !m_tvalid || m_tready. Holds m_* stable while m_tvalid=1 and m_tready=0.
- States:
  - PASS: s_tready = ld. An accepted beat is loaded into the output register next cycle (latency 1).
  - EXTRA: s_tready=0. On ld, load 16 x 0x10 with m_tlast=1, then go to PASS.
- Valid byte count n = number of contiguous ones in s_tkeep counting from bit 0 (0..16).
- Non-last beat (s_tlast=0):
  - Requires n=16. Data passes unchanged, m_tlast=0.
  - If s_tkeep != all ones, set err_keep; still pass the data with full keep.
- Last beat, n<16:
  - Bytes n..15 are replaced with pad value p = 16-n (8-bit); bytes 0..n-1 pass unchanged.
  - m_tlast=1; state stays PASS.
  - Case n=0: the output is 16 x 0x10, and no extra block is added.
- Last beat, n=16:
  - Data passes unchanged, m_tlast=0; go to EXTRA.
- Non-contiguous tkeep (any 1 above the first 0):
  - Set err_keep.
  - n is still the contiguous count; higher bytes are overwritten with pad.
- err_keep clears only on reset.
- Simultaneous events:
  - Output register accepted (m_tready=1) and a new input beat in the same cycle: the new beat loads with no bubble.
  - Leaving EXTRA: the EXTRA block loads on the same ld cycle; s_tready rises the following cycle.
- Back-to-back packets: no idle cycle is required except the one EXTRA cycle.
- m_tkeep is all ones on every valid output.
- Output block count per packet: ceil((L+1)/16) for an L-byte packet.

Optional Feature:
- Macro PKCS7_PAD_STATS_EN.
- When defined, add outputs:
  - pkt_cnt [31:0]: increments on each output handshake with m_tlast=1.
  - extra_cnt [31:0]: increments on each EXTRA block handshake.
- Both counters reset to 0 and wrap modulo 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header aes_axis_pkg:
  - AES_BLOCK_BYTES=16
  - PKCS7_FULL_PAD=8'h10
  - state encodings ST_PASS=1'b0, ST_EXTRA=1'b1
- One natural combinational sub-module, pkcs7_pad_lane:
  - Inputs: tdata and tkeep.
  - Outputs: n, padded data, and keep_err (non-contiguous mask).
  - The top level keeps the FSM, output register and sticky flag.

Test Plan:
- 5-byte packet 00..04, single beat keep=16'h001F, tlast=1 → one block: bytes 0..4 = 00..04, bytes 5..15 = 0x0B, m_tlast=1.
- 16-byte packet, keep=16'hFFFF, tlast=1 → data block with m_tlast=0, then 16 x 0x10 with m_tlast=1; s_tready=0 for exactly one cycle.
- 33-byte packet (keep FFFF, FFFF, 0001 last) with m_tready toggling 1,0,0,1 → 3 blocks; last block = byte 0 then 15 x 0x0F; m_* stable during stalls; no drop or duplicate.
- Non-last beat keep=16'h00FF → err_keep=1 and stays 1; non-contiguous last beat keep=16'h0005 → n=1, bytes 1..15 = 0x0F.
- rst_n pulsed low while in EXTRA with m_tvalid=1 → m_tvalid=0 immediately; next packet of 1 byte (AA) → AA followed by 15 x 0x0F.
- Two packets back-to-back (3 bytes, then 16 bytes), m_tready=1 constant → outputs 0x0D-padded block, data block, 0x10 block; with PKCS7_PAD_STATS_EN, pkt_cnt=2 and extra_cnt=1.

Source files
------------

// File: rtl/aes_axis_pkg.sv
// Shared constants for the AES AXI-Stream datapath.
// Block size, full PKCS#7 pad byte and padder FSM state codes.
package aes_axis_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    localparam logic [7:0] PKCS7_FULL_PAD = 8'h10;

    localparam logic [0:0] ST_PASS  = 1'b0;
    localparam logic [0:0] ST_EXTRA = 1'b1;

endpackage

// File: rtl/pkcs7_pad_lane.sv
// Combinational PKCS#7 lane: counts contiguous valid bytes and pads the rest.
// Ports: tdata/tkeep in; n (0..16), pdata (padded block), keep_err out.
module pkcs7_pad_lane
    import aes_axis_pkg::*;
(
    input  logic [127:0] tdata,
    input  logic [15:0]  tkeep,
    output logic [4:0]   n,
    output logic [127:0] pdata,
    output logic         keep_err
);

    logic        stop;
    logic [15:0] mask;
    logic [7:0]  pad;

    always_comb begin
        n    = 5'd0;
        stop = 1'b0;
        for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            if (!stop && tkeep[i]) begin
                n = n + 5'd1;
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        pad  = 8'd16 - {3'b000, n};
        mask = '0;
        for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            mask[i]        = (5'(i) < n);
            pdata[8*i +: 8] = mask[i] ? tdata[8*i +: 8] : pad;
        end
        // Any set bit above the first hole makes the mask non-contiguous.
        keep_err = |(tkeep & ~mask);
    end

endmodule

// File: rtl/axis_pkcs7_pad.sv
// AXI-Stream PKCS#7 padder: emits full 16-byte blocks, adds 0x10 block on boundary.
// Ports: s_* input stream, m_* output stream, err_keep sticky flag; stats under PKCS7_PAD_STATS_EN.
module axis_pkcs7_pad
    import aes_axis_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              err_keep
`ifdef PKCS7_PAD_STATS_EN
    ,
    output logic [31:0]       pkt_cnt,
    output logic [31:0]       extra_cnt
`endif
);

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
    logic [KEEP_W-1:0] m_tkeep_q, m_tkeep_d;
    logic              m_tlast_q, m_tlast_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              err_q, err_d;
    logic              ld;

    logic [4:0]        lane_n;
    logic [DATA_W-1:0] lane_data;
    logic              lane_err;

    pkcs7_pad_lane u_lane (
        .tdata    (s_tdata),
        .tkeep    (s_tkeep),
        .n        (lane_n),
        .pdata    (lane_data),
        .keep_err (lane_err)
    );

    assign ld       = !m_tvalid_q || m_tready;
    assign s_tready = (state_q == ST_PASS) && ld;

    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tlast  = m_tlast_q;
    assign m_tvalid = m_tvalid_q;
    assign err_keep = err_q;

    always_comb begin
        state_d    = state_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        err_d      = err_q;
        if (ld) begin
            unique case (state_q)
                ST_EXTRA: begin
                    m_tdata_d  = {AES_BLOCK_BYTES{PKCS7_FULL_PAD}};
                    m_tkeep_d  = '1;
                    m_tlast_d  = 1'b1;
                    m_tvalid_d = 1'b1;
                    state_d    = ST_PASS;
                end
                default: begin
                    m_tvalid_d = s_tvalid;
                    if (s_tvalid) begin
                        m_tkeep_d = '1;
                        if (!s_tlast) begin
                            m_tdata_d = s_tdata;
                            m_tlast_d = 1'b0;
                            if (s_tkeep != '1) err_d = 1'b1;
                        end else if (lane_n == 5'd16) begin
                            // Boundary end: pad goes in a block of its own.
                            m_tdata_d = s_tdata;
                            m_tlast_d = 1'b0;
                            state_d   = ST_EXTRA;
                        end else begin
                            m_tdata_d = lane_data;
                            m_tlast_d = 1'b1;
                            if (lane_err) err_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PASS;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
            err_q      <= err_d;
        end
    end

`ifdef PKCS7_PAD_STATS_EN
    logic        extra_q, extra_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] extra_cnt_q, extra_cnt_d;
    logic        m_hs;

    assign m_hs = m_tvalid_q && m_tready;

    // Marks that the output register currently holds the inserted pad block.
    always_comb begin
        extra_d     = extra_q;
        pkt_cnt_d   = pkt_cnt_q;
        extra_cnt_d = extra_cnt_q;
        if (ld) begin
            if (state_q == ST_EXTRA) extra_d = 1'b1;
            else                     extra_d = 1'b0;
        end
        if (m_hs && m_tlast_q) pkt_cnt_d   = pkt_cnt_q + 32'd1;
        if (m_hs && extra_q)   extra_cnt_d = extra_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            extra_q     <= 1'b0;
            pkt_cnt_q   <= '0;
            extra_cnt_q <= '0;
        end else begin
            extra_q     <= extra_d;
            pkt_cnt_q   <= pkt_cnt_d;
            extra_cnt_q <= extra_cnt_d;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign extra_cnt = extra_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pkcs7_pad.sv
// Scoreboard bench for axis_pkcs7_pad with a packet-level PKCS#7 model.
// Random and directed packets; monitor checks every output handshake.
module tb_axis_pkcs7_pad;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] s_tdata = '0;
    logic [15:0]  s_tkeep = '0;
    logic         s_tlast = 1'b0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready = 1'b0;
    logic         err_keep;
`ifdef PKCS7_PAD_STATS_EN
    logic [31:0]  pkt_cnt;
    logic [31:0]  extra_cnt;
`endif

    axis_pkcs7_pad dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .err_keep (err_keep)
`ifdef PKCS7_PAD_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .extra_cnt(extra_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic         l;
    } blk_t;

    blk_t         exp_q[$];
    logic [127:0] bd[$];
    logic [15:0]  bk[$];
    int           checks = 0;
    int           errors = 0;
    logic         exp_err = 1'b0;
    int           rmode = 0;
    logic         s_hs_q = 1'b0;
    logic         stall_q = 1'b0;
    logic [127:0] stall_d;
    logic         stall_l;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) s_hs_q <= rst_n && s_tvalid && s_tready;

    initial begin
        int pi;
        logic pat[4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        pi = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: m_tready = 1'b1;
                1: m_tready = 1'($urandom_range(0, 1));
                2: begin m_tready = pat[pi]; pi = (pi + 1) % 4; end
                default: m_tready = 1'b0;
            endcase
        end
    end

    // Monitor: inputs only change just after posedge, so negedge state
    // predicts the handshake at the next posedge.
    initial begin
        blk_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_q = 1'b0;
            end else if (m_tvalid) begin
                chk("m_tkeep", 128'(m_tkeep), 128'hFFFF);
                if (stall_q) begin
                    chk("stall_data", m_tdata, stall_d);
                    chk("stall_last", 128'(m_tlast), 128'(stall_l));
                end
                if (m_tready) begin
                    stall_q = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_block: got %h", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("blk_data", m_tdata, e.d);
                        chk("blk_last", 128'(m_tlast), 128'(e.l));
                    end
                end else begin
                    stall_q = 1'b1;
                    stall_d = m_tdata;
                    stall_l = m_tlast;
                end
            end
        end
    end

    task automatic add_beat(input logic [127:0] d, input logic [15:0] k);
        bd.push_back(d);
        bk.push_back(k);
    endtask

    // Model: packet bytes = whole non-last beats plus the contiguous
    // prefix of the last beat; then standard PKCS#7 over the byte stream.
    task automatic run_pkt();
        byte unsigned st[$];
        int   n, p, nb, cyc;
        blk_t e;
        for (int b = 0; b < bd.size(); b++) begin
            if (b != bd.size() - 1) begin
                for (int i = 0; i < 16; i++) st.push_back(bd[b][8*i +: 8]);
                if (bk[b] != 16'hFFFF) exp_err = 1'b1;
            end else begin
                n = 0;
                while (n < 16 && bk[b][n]) n++;
                for (int i = 0; i < n; i++) st.push_back(bd[b][8*i +: 8]);
                if ((bk[b] >> n) != 16'h0) exp_err = 1'b1;
            end
        end
        p = 16 - (st.size() % 16);
        for (int i = 0; i < p; i++) st.push_back(8'(p));
        nb = st.size() / 16;
        for (int k = 0; k < nb; k++) begin
            for (int i = 0; i < 16; i++) e.d[8*i +: 8] = st[16*k + i];
            e.l = (k == nb - 1);
            exp_q.push_back(e);
        end
        for (int b = 0; b < bd.size(); b++) begin
            s_tdata  = bd[b];
            s_tkeep  = bk[b];
            s_tlast  = (b == bd.size() - 1);
            s_tvalid = 1'b1;
            cyc = 0;
            do begin
                @(posedge clk);
                #1;
                cyc++;
            end while (!s_hs_q && cyc < 1000);
            if (!s_hs_q) begin
                checks++;
                errors++;
                $display("FAIL input_timeout: beat %0d not accepted", b);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        bd.delete();
        bk.delete();
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || m_tvalid) && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
        chk("err_keep", 128'(err_keep), 128'(exp_err));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] seq(input int base);
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(base + i);
        return d;
    endfunction

    task automatic rand_pkt(input int len);
        int r = len % 16;
        int f = len / 16;
        if (r == 0 && f > 0) begin
            for (int i = 0; i < f; i++) add_beat(rnd128(), 16'hFFFF);
        end else begin
            for (int i = 0; i < f; i++) add_beat(rnd128(), 16'hFFFF);
            add_beat(rnd128(), 16'((32'd1 << r) - 1));
        end
        run_pkt();
    endtask

    initial begin
        logic [31:0] pc0, ec0;
        #2;
        chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_m_tdata", m_tdata, 128'd0);
        chk("rst_m_tkeep", 128'(m_tkeep), 128'd0);
        chk("rst_m_tlast", 128'(m_tlast), 128'd0);
        chk("rst_err_keep", 128'(err_keep), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rmode = 0;
        add_beat(seq(0), 16'h001F);
        run_pkt();
        drain();

        add_beat(seq(8'h40), 16'hFFFF);
        run_pkt();
        chk("extra_tready_lo", 128'(s_tready), 128'd0);
        @(posedge clk);
        #1;
        chk("extra_tready_hi", 128'(s_tready), 128'd1);
        drain();

        rmode = 2;
        add_beat(rnd128(), 16'hFFFF);
        add_beat(rnd128(), 16'hFFFF);
        add_beat(rnd128(), 16'h0001);
        run_pkt();
        drain();

        rmode = 0;
        add_beat(rnd128(), 16'h00FF);
        add_beat(rnd128(), 16'h0005);
        run_pkt();
        drain();
        @(posedge clk);
        #1;
        chk("err_sticky", 128'(err_keep), 128'd1);

        rmode = 3;
        add_beat(seq(8'h80), 16'hFFFF);
        run_pkt();
        #3;
        chk("pre_rst_valid", 128'(m_tvalid), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(m_tvalid), 128'd0);
        chk("async_rst_err", 128'(err_keep), 128'd0);
        exp_q.delete();
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rmode = 0;
        add_beat(128'h0000_0000_0000_0000_0000_0000_0000_00AA, 16'h0001);
        run_pkt();
        drain();

`ifdef PKCS7_PAD_STATS_EN
        pc0 = pkt_cnt;
        ec0 = extra_cnt;
`else
        pc0 = 32'd0;
        ec0 = 32'd0;
`endif
        add_beat(seq(1), 16'h0007);
        run_pkt();
        add_beat(seq(2), 16'hFFFF);
        run_pkt();
        drain();
`ifdef PKCS7_PAD_STATS_EN
        chk("pkt_cnt", 128'(pkt_cnt - pc0), 128'd2);
        chk("extra_cnt", 128'(extra_cnt - ec0), 128'd1);
`endif

        rmode = 3;
        add_beat(seq(9), 16'h0000);
        run_pkt();
        rmode = 0;
        drain();

        for (int t = 0; t < 40; t++) begin
            rmode = (t % 3 == 0) ? 0 : 1;
            rand_pkt(int'($urandom_range(0, 50)));
            if (t % 5 == 4) drain();
        end
        drain();
        if (pc0 != ec0 + 32'hFFFF_FFFF) begin end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
